codec_cfg_sequencer: RTL and testbench
======================================

# codec_cfg_sequencer

Configuration sequencer for the WM8731 audio codec on the waveform-generator board. After reset it waits out codec power-up, then walks a fixed 9-entry register table through the existing I2C byte-write master. It retries NACKed writes and reports progress on a 4-bit status. Once configured, it schedules runtime rewrites of headphone volume and DAC mute whenever the user controls change. It sits between `top` user controls and the I2C master that drives `I2C_SCLK`/`I2C_SDAT`.

## Interface
- `DEV_ADDR`, 7'h1A: codec 7-bit I2C address, passed through on `o_dev_addr`.
- `PWRUP_CYC`, 50_000: clocks waited after reset before the first write (1 ms at 50 MHz).
- `GAP_CYC`, 500: idle clocks between the end of one transaction and the next `o_req`.
- `MAX_RETRY`, 3: extra attempts after a NACK before entering error.

Ports:
- `clk_50m`  in  1  system clock, 50 MHz.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_hp_vol`  in  7  headphone volume code, WM8731 LHPVOL format.
- `i_mute`  in  1  level; 1 = DAC soft-mute.
- `o_req`  out  1  transaction request to the I2C master; held until `i_done`.
- `o_dev_addr`  out  7  equals `DEV_ADDR`.
- `o_data`  out  16  {reg_addr[6:0], reg_data[8:0]}; stable while `o_req`=1.
- `i_done`  in  1  one-cycle pulse from the master at transaction end.
- `i_nack`  in  1  qualifies `i_done`; 1 = NACK received.
- `o_cfg_done`  out  1  high once the init table has completed; stays high in RUN.
- `o_status`  out  4  table index 0–8 during init; 4'hF = running; 4'hE = error.

## Operation
- Init table in index order (reg, data):
  - 0: R15 0x000 (reset)
  - 1: R0 0x117
  - 2: R2 0x100|`i_hp_vol`
  - 3: R4 0x012
  - 4: R5 `i_mute` ? 0x008 : 0x000
  - 5: R6 0x000
  - 6: R7 0x002
  - 7: R8 0x000
  - 8: R9 0x001 (active)
- Entries 2 and 4 sample `i_hp_vol`/`i_mute` when the entry is loaded into `o_data`. The sampled values go into shadow registers `vol_sh` and `mute_sh`.
- States:
  - PWRUP: count `PWRUP_CYC`, then go to ISSUE.
  - ISSUE: assert `o_req` with the current entry, go to WAIT.
  - WAIT: hold `o_req` until `i_done`.
    - ACK: go to GAP.
    - NACK with retries remaining: increment the retry count, go to GAP, then reissue the same entry.
    - NACK with retries exhausted: go to ERR.
  - GAP: count `GAP_CYC`. Then: next entry to ISSUE; after entry 8, go to RUN; for a retry, reissue the same entry.
  - RUN: idle until `i_mute`≠`mute_sh` or `i_hp_vol`≠`vol_sh`, then issue R5 or R2 via ISSUE/WAIT/GAP and return to RUN.
  - ERR: sticky; only `i_rst` exits.
- Retry count clears on every ACK.
- If both mute and volume differ in RUN, R5 (mute) is written first. The volume change is picked up on the next RUN cycle.
- Shadow registers update on ACK only.
- If the input changes again during a runtime write, the new value is caught on return to RUN. No change is ever lost; intermediate values may be skipped.
- `i_done` is ignored outside WAIT. `i_nack` is ignored unless `i_done`=1.

## Timing
- Reset values:
  - `o_req`=0, `o_data`=16'h0000, `o_cfg_done`=0, `o_status`=4'h0.
  - State PWRUP, counters 0.
  - `vol_sh`=0, `mute_sh`=0.
- `i_rst` mid-transaction:
  - `o_req` falls on the same edge.
  - The sequence restarts from PWRUP, index 0.
  - `o_cfg_done` clears.
- First `o_req` rises exactly `PWRUP_CYC`+1 clocks after the edge where `i_rst` deasserts.
- `o_req` falls on the edge where `i_done` is sampled high. The next `o_req` rises `GAP_CYC`+1 clocks later.
- `o_data` is registered and valid in the same cycle `o_req` first rises. It is unchanged until `o_req` falls.
- `o_cfg_done` and `o_status`=F rise on the cycle after the final gap ends.
- Runtime change: `o_req` rises 2 clocks after the input differs from its shadow (1-cycle compare, 1-cycle ISSUE).
- Counters are 16-bit; `PWRUP_CYC` and `GAP_CYC` must be ≤ 65535.

## Test plan
- **Clean init:** slave model ACKs all writes; `i_hp_vol`=7'h79, `i_mute`=0 -> 9 requests. `o_data` sequence is 0x1E00, 0x0117, 0x0579, 0x0812, 0x0A00, 0x0C00, 0x0E02, 0x1000, 0x1201. Spacing is `GAP_CYC`+1 between requests. `o_cfg_done`=1 and `o_status`=F at the end.
- **NACK recovery:** NACK entry 3 twice, then ACK -> 0x0812 is issued 3 times. Init completes with no status error.
- **Retry exhaustion:** NACK entry 6 four times -> `o_status`=E and `o_req` stays 0 afterwards. `o_cfg_done`=0 until `i_rst`.
- **Runtime update:** in RUN, toggle `i_mute` 0→1 and `i_hp_vol`→7'h50 on the same cycle. Two writes follow: 0x0A08 first, then 0x0550.
- **Reset mid-write:** assert `i_rst` while `o_req`=1 at index 4 -> `o_req`=0 on the next edge. After release, index 0 (0x1E00) reappears after exactly `PWRUP_CYC`+1 clocks.
- **Spurious handshake:** pulse `i_done` with `i_nack`=1 during PWRUP and GAP -> no state change and no retry consumed.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: powers up, walks the 9-entry init table through the
// I2C byte-write master with NACK retries, then rewrites volume/mute when user controls change.
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         PWRUP_CYC = 50_000,
    parameter int         GAP_CYC   = 500,
    parameter int         MAX_RETRY = 3
) (
    input  logic        clk_50m,
    input  logic        i_rst,
    input  logic [6:0]  i_hp_vol,
    input  logic        i_mute,
    output logic        o_req,
    output logic [6:0]  o_dev_addr,
    output logic [15:0] o_data,
    input  logic        i_done,
    input  logic        i_nack,
    output logic        o_cfg_done,
    output logic [3:0]  o_status
);

    localparam logic [15:0] PWRUP_LAST  = 16'(PWRUP_CYC - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);
    localparam logic [3:0]  MAX_RETRY_C = 4'(MAX_RETRY);
    localparam logic [3:0]  LAST_IDX    = 4'd8;
    localparam logic [6:0]  REG_HPVOL   = 7'd2;
    localparam logic [6:0]  REG_DIGPATH = 7'd5;
    localparam logic [3:0]  STATUS_RUN  = 4'hF;
    localparam logic [3:0]  STATUS_ERR  = 4'hE;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [3:0]  idx_r, idx_s;
    logic [3:0]  retry_r, retry_s;
    logic        req_r, req_s;
    logic [15:0] data_r, data_s;
    logic [6:0]  vol_sh_r, vol_sh_s;
    logic        mute_sh_r, mute_sh_s;
    logic        cfg_done_r, cfg_done_s;
    logic [3:0]  status_r, status_s;

    // Init table word {reg_addr, reg_data} for a given index and current user controls.
    function automatic logic [15:0] entry_word(input logic [3:0] idx, input logic [6:0] vol,
                                               input logic mute);
        logic [15:0] word;
        case (idx)
            4'd0:    word = {7'd15, 9'h000};
            4'd1:    word = {7'd0,  9'h117};
            4'd2:    word = {REG_HPVOL, 9'h100 | {2'b00, vol}};
            4'd3:    word = {7'd4,  9'h012};
            4'd4:    word = {REG_DIGPATH, (mute ? 9'h008 : 9'h000)};
            4'd5:    word = {7'd6,  9'h000};
            4'd6:    word = {7'd7,  9'h002};
            4'd7:    word = {7'd8,  9'h000};
            4'd8:    word = {7'd9,  9'h001};
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        retry_s    = retry_r;
        req_s      = req_r;
        data_s     = data_r;
        vol_sh_s   = vol_sh_r;
        mute_sh_s  = mute_sh_r;
        cfg_done_s = cfg_done_r;
        status_s   = status_r;
        case (state_r)
            ST_PWRUP: begin
                if (cnt_r == PWRUP_LAST) begin
                    state_s = ST_ISSUE;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_ISSUE: begin
                req_s   = 1'b1;
                state_s = ST_WAIT;
                // A retry resends the exact word that was NACKed.
                if (retry_r != 4'd0) begin
                    data_s = data_r;
                end else if (cfg_done_r) begin
                    if (i_mute != mute_sh_r) begin
                        data_s = entry_word(4'd4, i_hp_vol, i_mute);
                    end else begin
                        data_s = entry_word(4'd2, i_hp_vol, i_mute);
                    end
                end else begin
                    data_s = entry_word(idx_r, i_hp_vol, i_mute);
                end
            end
            ST_WAIT: begin
                if (i_done) begin
                    req_s = 1'b0;
                    cnt_s = 16'd0;
                    if (!i_nack) begin
                        retry_s = 4'd0;
                        state_s = ST_GAP;
                        if (data_r[15:9] == REG_HPVOL) begin
                            vol_sh_s = data_r[6:0];
                        end else if (data_r[15:9] == REG_DIGPATH) begin
                            mute_sh_s = data_r[3];
                        end else begin
                            vol_sh_s = vol_sh_r;
                        end
                    end else if (retry_r < MAX_RETRY_C) begin
                        retry_s = retry_r + 4'd1;
                        state_s = ST_GAP;
                    end else begin
                        state_s  = ST_ERR;
                        status_s = STATUS_ERR;
                    end
                end else begin
                    req_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s = 16'd0;
                    if (retry_r != 4'd0) begin
                        state_s = ST_ISSUE;
                    end else if (cfg_done_r) begin
                        state_s = ST_RUN;
                    end else if (idx_r == LAST_IDX) begin
                        state_s    = ST_RUN;
                        cfg_done_s = 1'b1;
                        status_s   = STATUS_RUN;
                    end else begin
                        idx_s    = idx_r + 4'd1;
                        status_s = idx_r + 4'd1;
                        state_s  = ST_ISSUE;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_RUN: begin
                // Mute has priority in ISSUE; volume is picked up on the next pass.
                if ((i_mute != mute_sh_r) || (i_hp_vol != vol_sh_r)) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ERR: begin
                state_s  = ST_ERR;
                req_s    = 1'b0;
                status_s = STATUS_ERR;
            end
            default: begin
                state_s = ST_PWRUP;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50m) begin
        if (i_rst) begin
            state_r    <= ST_PWRUP;
            cnt_r      <= 16'd0;
            idx_r      <= 4'd0;
            retry_r    <= 4'd0;
            req_r      <= 1'b0;
            data_r     <= 16'h0000;
            vol_sh_r   <= 7'd0;
            mute_sh_r  <= 1'b0;
            cfg_done_r <= 1'b0;
            status_r   <= 4'h0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            retry_r    <= retry_s;
            req_r      <= req_s;
            data_r     <= data_s;
            vol_sh_r   <= vol_sh_s;
            mute_sh_r  <= mute_sh_s;
            cfg_done_r <= cfg_done_s;
            status_r   <= status_s;
        end
    end

    assign o_req      = req_r;
    assign o_data     = data_r;
    assign o_cfg_done = cfg_done_r;
    assign o_status   = status_r;
    assign o_dev_addr = DEV_ADDR;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Randomized self-checking bench for codec_cfg_sequencer against a table-driven reference model.
module tb_codec_cfg_sequencer;

    localparam int PWRUP = 30;
    localparam int GAP   = 6;
    localparam int BUDGET = PWRUP + GAP + 20;

    logic        clk_50m = 1'b0;
    logic        i_rst = 1'b1;
    logic [6:0]  i_hp_vol = 7'd0;
    logic        i_mute = 1'b0;
    logic        i_done = 1'b0;
    logic        i_nack = 1'b0;
    logic        o_req;
    logic [6:0]  o_dev_addr;
    logic [15:0] o_data;
    logic        o_cfg_done;
    logic [3:0]  o_status;

    int chk_cnt = 0;
    int pass_cnt = 0;

    codec_cfg_sequencer #(.DEV_ADDR(7'h1A), .PWRUP_CYC(PWRUP), .GAP_CYC(GAP), .MAX_RETRY(3)) dut (
        .clk_50m(clk_50m), .i_rst(i_rst), .i_hp_vol(i_hp_vol), .i_mute(i_mute),
        .o_req(o_req), .o_dev_addr(o_dev_addr), .o_data(o_data), .i_done(i_done),
        .i_nack(i_nack), .o_cfg_done(o_cfg_done), .o_status(o_status)
    );

    always #5 clk_50m = ~clk_50m;

    // Reference: register number * 512 + 9-bit register value.
    function automatic logic [15:0] exp_word(input int e, input logic [6:0] vol, input logic m);
        int reg_no[9];
        int dat[9];
        int d;
        reg_no = '{15, 0, 2, 4, 5, 6, 7, 8, 9};
        dat    = '{0, 'h117, 0, 'h012, 0, 0, 'h002, 0, 'h001};
        d = dat[e];
        if (e == 2) d = 'h100 + int'(vol);
        if (e == 4) d = m ? 8 : 0;
        return 16'(reg_no[e] * 512 + d);
    endfunction

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_done = 1'b0; i_nack = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;
    endtask

    // Edges counted until o_req is seen high.
    task automatic wait_req(output int n, output logic [15:0] d, output bit ok);
        n = 0; ok = 1'b0; d = 16'h0000;
        while (!ok && n < BUDGET) begin
            step();
            n++;
            if (o_req === 1'b1) begin
                ok = 1'b1;
                d = o_data;
            end
        end
    endtask

    // Slave response; stable reports whether req/data held and req dropped on done.
    task automatic complete(input int hold, input bit nack, output bit stable);
        logic [15:0] d0;
        d0 = o_data;
        stable = 1'b1;
        repeat (hold) begin
            step();
            if (o_req !== 1'b1 || o_data !== d0) stable = 1'b0;
        end
        i_done = 1'b1; i_nack = nack;
        step();
        i_done = 1'b0; i_nack = 1'($urandom_range(0, 1));
        if (o_req !== 1'b0) stable = 1'b0;
    endtask

    task automatic bring_up(input logic [6:0] vol, input logic m, output bit ok);
        int n; logic [15:0] d; bit r; bit st;
        i_hp_vol = vol; i_mute = m;
        do_reset();
        ok = 1'b1;
        for (int e = 0; e < 9; e++) begin
            wait_req(n, d, r);
            if (!r) ok = 1'b0;
            complete(0, 1'b0, st);
        end
        repeat (GAP + 2) step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) step();
        chk_cnt++; if (o_req !== 1'b0) $display("FAIL reset_req: got %b want 0", o_req); else pass_cnt++;
        chk_cnt++; if (o_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", o_data); else pass_cnt++;
        chk_cnt++; if (o_cfg_done !== 1'b0) $display("FAIL reset_cfg_done: got %b want 0", o_cfg_done); else pass_cnt++;
        chk_cnt++; if (o_status !== 4'h0) $display("FAIL reset_status: got %h want 0", o_status); else pass_cnt++;
        chk_cnt++; if (o_dev_addr !== 7'h1A) $display("FAIL dev_addr: got %h want 1a", o_dev_addr); else pass_cnt++;
    endtask

    task automatic test_init_sequence(input logic [6:0] vol, input logic m, input int nacks[9], input string tag);
        int n; logic [15:0] d; bit ok; bit st; bit first;
        i_hp_vol = vol; i_mute = m;
        do_reset();
        first = 1'b1;
        for (int e = 0; e < 9; e++) begin
            for (int a = 0; a <= nacks[e]; a++) begin
                wait_req(n, d, ok);
                chk_cnt++; if (!ok) begin $display("FAIL %s_timeout: entry %0d no o_req", tag, e); return; end else pass_cnt++;
                chk_cnt++; if (n != (first ? PWRUP + 1 : GAP + 1))
                    $display("FAIL %s_spacing: entry %0d got %0d want %0d", tag, e, n, first ? PWRUP + 1 : GAP + 1); else pass_cnt++;
                first = 1'b0;
                chk_cnt++; if (d !== exp_word(e, vol, m))
                    $display("FAIL %s_data: entry %0d got %h want %h", tag, e, d, exp_word(e, vol, m)); else pass_cnt++;
                chk_cnt++; if (o_status !== 4'(e) || o_cfg_done !== 1'b0)
                    $display("FAIL %s_status: entry %0d got %h/%b want %h/0", tag, e, o_status, o_cfg_done, 4'(e)); else pass_cnt++;
                complete(int'($urandom_range(0, 3)), a < nacks[e], st);
                chk_cnt++; if (!st) $display("FAIL %s_handshake: entry %0d got unstable want stable", tag, e); else pass_cnt++;
            end
        end
        repeat (GAP - 1) step();
        chk_cnt++; if (o_cfg_done !== 1'b0) $display("FAIL %s_cfg_done_early: got %b want 0", tag, o_cfg_done); else pass_cnt++;
        step();
        chk_cnt++; if (o_cfg_done !== 1'b1 || o_status !== 4'hF)
            $display("FAIL %s_done: got %b/%h want 1/f", tag, o_cfg_done, o_status); else pass_cnt++;
        repeat (5) step();
        chk_cnt++; if (o_req !== 1'b0 || o_status !== 4'hF)
            $display("FAIL %s_idle: got req %b status %h want 0/f", tag, o_req, o_status); else pass_cnt++;
    endtask

    task automatic test_retry_exhaustion();
        int n; logic [15:0] d; bit ok; bit st; bit seen;
        logic [6:0] vol; logic m;
        vol = 7'($urandom); m = 1'($urandom);
        i_hp_vol = vol; i_mute = m;
        do_reset();
        for (int e = 0; e < 6; e++) begin
            wait_req(n, d, ok);
            chk_cnt++; if (d !== exp_word(e, vol, m)) $display("FAIL exh_data: entry %0d got %h want %h", e, d, exp_word(e, vol, m)); else pass_cnt++;
            complete(0, 1'b0, st);
        end
        for (int a = 0; a < 4; a++) begin
            wait_req(n, d, ok);
            chk_cnt++; if (!ok || n != GAP + 1 || d !== 16'h0E02)
                $display("FAIL exh_attempt: attempt %0d got ok %b n %0d data %h want 1/%0d/0e02", a, ok, n, d, GAP + 1); else pass_cnt++;
            complete(1, 1'b1, st);
        end
        chk_cnt++; if (o_status !== 4'hE || o_req !== 1'b0 || o_cfg_done !== 1'b0)
            $display("FAIL exh_err: got status %h req %b done %b want e/0/0", o_status, o_req, o_cfg_done); else pass_cnt++;
        seen = 1'b0;
        repeat (PWRUP + 3 * GAP) begin
            step();
            if (o_req !== 1'b0 || o_cfg_done !== 1'b0 || o_status !== 4'hE) seen = 1'b1;
        end
        chk_cnt++; if (seen) $display("FAIL exh_sticky: got activity after error want none"); else pass_cnt++;
    endtask

    task automatic test_runtime_update();
        int n; logic [15:0] d; bit ok; bit st; bit first; bit seen; int guard;
        logic [6:0] vsh; logic msh; logic [15:0] expw;
        vsh = 7'($urandom_range(0, 79));
        msh = 1'b0;
        bring_up(vsh, msh, ok);
        chk_cnt++; if (!ok || o_cfg_done !== 1'b1) $display("FAIL rt_bringup: got ok %b done %b want 1/1", ok, o_cfg_done); else pass_cnt++;
        i_mute = 1'b1; i_hp_vol = 7'h50;
        wait_req(n, d, ok);
        chk_cnt++; if (n != 2 || d !== 16'h0A08) $display("FAIL rt_mute_first: got n %0d data %h want 2/0a08", n, d); else pass_cnt++;
        complete(1, 1'b0, st);
        wait_req(n, d, ok);
        chk_cnt++; if (n != GAP + 2 || d !== 16'h0550) $display("FAIL rt_vol_second: got n %0d data %h want %0d/0550", n, d, GAP + 2); else pass_cnt++;
        complete(1, 1'b0, st);
        msh = 1'b1; vsh = 7'h50;
        for (int it = 0; it < 8; it++) begin
            seen = 1'b0;
            repeat (GAP + 5) begin
                step();
                if (o_req !== 1'b0) seen = 1'b1;
            end
            chk_cnt++; if (seen || o_cfg_done !== 1'b1 || o_status !== 4'hF)
                $display("FAIL rt_idle: iter %0d got req_seen %b done %b status %h want 0/1/f", it, seen, o_cfg_done, o_status); else pass_cnt++;
            i_hp_vol = ($urandom_range(0, 3) == 0) ? vsh : 7'($urandom);
            i_mute = 1'($urandom);
            first = 1'b1; guard = 0;
            while ((i_mute !== msh || i_hp_vol !== vsh) && guard < 6) begin
                guard++;
                expw = (i_mute !== msh) ? 16'(5 * 512 + (i_mute ? 8 : 0)) : 16'(2 * 512 + 256 + int'(i_hp_vol));
                wait_req(n, d, ok);
                chk_cnt++; if (!ok || n != (first ? 2 : GAP + 2) || d !== expw)
                    $display("FAIL rt_write: iter %0d got ok %b n %0d data %h want 1/%0d/%h", it, ok, n, d, first ? 2 : GAP + 2, expw); else pass_cnt++;
                first = 1'b0;
                if ($urandom_range(0, 2) == 0) i_hp_vol = 7'($urandom);
                complete(int'($urandom_range(0, 2)), 1'b0, st);
                if (expw[15:9] == 7'd5) msh = expw[3];
                else vsh = expw[6:0];
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int n; logic [15:0] d; bit ok; bit st;
        logic [6:0] vol; logic m;
        vol = 7'($urandom); m = 1'($urandom);
        i_hp_vol = vol; i_mute = m;
        do_reset();
        for (int e = 0; e < 4; e++) begin
            wait_req(n, d, ok);
            complete(0, 1'b0, st);
        end
        wait_req(n, d, ok);
        chk_cnt++; if (!ok || d !== exp_word(4, vol, m)) $display("FAIL rmw_entry4: got %h want %h", d, exp_word(4, vol, m)); else pass_cnt++;
        i_rst = 1'b1;
        step();
        chk_cnt++; if (o_req !== 1'b0 || o_data !== 16'h0000 || o_status !== 4'h0 || o_cfg_done !== 1'b0)
            $display("FAIL rmw_drop: got req %b data %h status %h want 0/0000/0", o_req, o_data, o_status); else pass_cnt++;
        i_rst = 1'b0;
        wait_req(n, d, ok);
        chk_cnt++; if (!ok || n != PWRUP + 1 || d !== 16'h1E00)
            $display("FAIL rmw_restart: got n %0d data %h want %0d/1e00", n, d, PWRUP + 1); else pass_cnt++;
        complete(0, 1'b0, st);
        bring_up(vol, m, ok);
        i_rst = 1'b1;
        step();
        chk_cnt++; if (o_cfg_done !== 1'b0 || o_status !== 4'h0)
            $display("FAIL rmw_run_reset: got done %b status %h want 0/0", o_cfg_done, o_status); else pass_cnt++;
        i_rst = 1'b0;
    endtask

    task automatic test_spurious();
        int n; logic [15:0] d; bit ok; bit st;
        i_hp_vol = 7'h33; i_mute = 1'b0;
        do_reset();
        repeat (5) step();
        i_done = 1'b1; i_nack = 1'b1;
        step();
        i_done = 1'b0; i_nack = 1'b0;
        wait_req(n, d, ok);
        chk_cnt++; if (n + 6 != PWRUP + 1 || d !== 16'h1E00)
            $display("FAIL spur_pwrup: got n %0d data %h want %0d/1e00", n + 6, d, PWRUP + 1); else pass_cnt++;
        complete(0, 1'b0, st);
        for (int a = 0; a < 4; a++) begin
            if (a < 2) begin
                repeat (2) step();
                i_done = 1'b1; i_nack = 1'b1;
                step();
                i_done = 1'b0; i_nack = 1'b0;
                wait_req(n, d, ok);
                n = n + 3;
            end else begin
                wait_req(n, d, ok);
            end
            chk_cnt++; if (n != GAP + 1 || d !== 16'h0117)
                $display("FAIL spur_gap: attempt %0d got n %0d data %h want %0d/0117", a, n, d, GAP + 1); else pass_cnt++;
            complete(0, a < 3, st);
        end
        wait_req(n, d, ok);
        chk_cnt++; if (d !== exp_word(2, 7'h33, 1'b0) || o_status !== 4'h2)
            $display("FAIL spur_retry_budget: got data %h status %h want %h/2", d, o_status, exp_word(2, 7'h33, 1'b0)); else pass_cnt++;
        complete(0, 1'b0, st);
    endtask

    initial begin
        int nk[9];
        test_reset();
        nk = '{default: 0};
        test_init_sequence(7'h79, 1'b0, nk, "clean");
        test_init_sequence(7'($urandom), 1'($urandom), nk, "clean_rand");
        nk = '{0, 0, 0, 2, 0, 0, 0, 0, 0};
        test_init_sequence(7'h79, 1'b0, nk, "nack3");
        for (int e = 0; e < 9; e++) nk[e] = int'($urandom_range(0, 3));
        test_init_sequence(7'($urandom), 1'($urandom), nk, "nack_rand");
        test_retry_exhaustion();
        test_runtime_update();
        test_reset_mid_write();
        test_spurious();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
